// File: rtl/sha256_pkg.sv
// Shared SHA-256 control types and constants for the round controller,
// the W/K schedule/constant generator and the compression datapath.
package sha256_pkg;

  localparam int unsigned SHA_ROUNDS = 64;
  localparam int unsigned SHA_CW     = $clog2(SHA_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    FINAL = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/round_counter.sv
// Mod-ROUNDS round index counter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance the index by one, wrapping ROUNDS-1 -> 0
//   count      : current round index
//   last       : count == ROUNDS-1 (decoded from the count register)
module round_counter #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned CW     = $clog2(ROUNDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == CW'(ROUNDS - 1));

  // Wrap explicitly so non-power-of-two ROUNDS still stays in range.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequences one SHA-256 compression per accepted start: message load,
// ROUNDS round-enable cycles driving the W/K generator index, then the
// final hash accumulate. Control only; owns no data.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   start       : request a block; accepted in IDLE or FINAL
//   first_block : sampled with accepted start; 1 = initialise hash to IV
//   abort       : cancel the current block (highest priority after reset)
//   count       : round index to the W/K generator, valid with round_en
//   load_msg    : 1-cycle pulse, datapath captures the 16 message words
//   init_hash   : 1-cycle pulse with load_msg on a first block
//   round_en    : high for ROUNDS consecutive cycles per block
//   add_hash    : 1-cycle pulse, H[i] += working variable
//   done        : 1-cycle pulse coincident with add_hash
//   busy        : high in LOAD, ROUND and FINAL
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA_ROUNDS,
  parameter int unsigned CW     = $clog2(ROUNDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          first_block,
  input  logic          abort,
  output logic [CW-1:0] count,
  output logic          load_msg,
  output logic          init_hash,
  output logic          round_en,
  output logic          add_hash,
  output logic          done,
  output logic          busy
);

  ctrl_state_t state;
  logic        cnt_last;
  logic        cnt_en;
  logic        cnt_clr;

  // Counter only runs in ROUND; any exit from ROUND (normal or abort)
  // leaves it at 0, so count is 0 whenever round_en is low.
  assign cnt_en  = (state == ROUND) && !abort;
  assign cnt_clr = abort || (state != ROUND);

  round_counter #(
    .ROUNDS (ROUNDS),
    .CW     (CW)
  ) u_round_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .last  (cnt_last)
  );

  // State and registered Moore outputs are updated together from the
  // next state, so each output is aligned with the state it decodes.
  // The init_hash register holds the first_block value latched at start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      load_msg  <= 1'b0;
      init_hash <= 1'b0;
      round_en  <= 1'b0;
      add_hash  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      load_msg  <= 1'b0;
      init_hash <= 1'b0;
      round_en  <= 1'b0;
      add_hash  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, FINAL: begin
            if (start) begin
              state     <= LOAD;
              load_msg  <= 1'b1;
              init_hash <= first_block;
              busy      <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          LOAD: begin
            state    <= ROUND;
            round_en <= 1'b1;
            busy     <= 1'b1;
          end
          ROUND: begin
            busy <= 1'b1;
            if (cnt_last) begin
              state    <= FINAL;
              add_hash <= 1'b1;
              done     <= 1'b1;
            end else begin
              round_en <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl.
module tb_sha256_round_ctrl;

  localparam int unsigned CW = 6;

  // Output pattern order: {load_msg, init_hash, round_en, add_hash, done, busy}
  localparam logic [5:0] P_IDLE = 6'b000000;
  localparam logic [5:0] P_LDI  = 6'b110001;
  localparam logic [5:0] P_LD   = 6'b100001;
  localparam logic [5:0] P_RND  = 6'b001001;
  localparam logic [5:0] P_FIN  = 6'b000111;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          first_block;
  logic          abort;
  logic [CW-1:0] count;
  logic          load_msg, init_hash, round_en, add_hash, done, busy;
  logic [5:0]    obs;

  int vectors = 0;
  int errors  = 0;

  assign obs = {load_msg, init_hash, round_en, add_hash, done, busy};

  always #5 clk = ~clk;

  sha256_round_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_block (first_block),
    .abort       (abort),
    .count       (count),
    .load_msg    (load_msg),
    .init_hash   (init_hash),
    .round_en    (round_en),
    .add_hash    (add_hash),
    .done        (done),
    .busy        (busy)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; first_block = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({obs, count} !== {P_IDLE, 6'd0}) begin
        errors++;
        $display("FAIL reset cyc%0d: got obs=%b count=%0d, want obs=%b count=0", i, obs, count, P_IDLE);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({obs, count} !== {P_IDLE, 6'd0}) begin
        errors++;
        $display("FAIL idle cyc%0d: got obs=%b count=%0d, want obs=%b count=0", i, obs, count, P_IDLE);
      end
    end
  endtask

  task automatic test_single_block();
    start = 1'b1; first_block = 1'b1;
    tick();
    start = 1'b0; first_block = 1'b0;
    vectors++;
    if ({obs, count} !== {P_LDI, 6'd0}) begin
      errors++;
      $display("FAIL single load: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_LDI);
    end
    for (int i = 0; i < 64; i++) begin
      tick();
      vectors++;
      if ({obs, count} !== {P_RND, 6'(i)}) begin
        errors++;
        $display("FAIL single round%0d: got obs=%b count=%0d, want obs=%b count=%0d", i, obs, count, P_RND, i);
      end
    end
    tick();
    vectors++;
    if ({obs, count} !== {P_FIN, 6'd0}) begin
      errors++;
      $display("FAIL single final: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_FIN);
    end
    tick();
    vectors++;
    if ({obs, count} !== {P_IDLE, 6'd0}) begin
      errors++;
      $display("FAIL single idle: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_load;
    start = 1'b1; first_block = 1'b1;
    tick();
    first_block = 1'b0;
    for (int b = 0; b < 3; b++) begin
      exp_load = (b == 0) ? P_LDI : P_LD;
      vectors++;
      if ({obs, count} !== {exp_load, 6'd0}) begin
        errors++;
        $display("FAIL b2b load blk%0d: got obs=%b count=%0d, want obs=%b count=0", b, obs, count, exp_load);
      end
      for (int i = 0; i < 64; i++) begin
        tick();
        vectors++;
        if ({obs, count} !== {P_RND, 6'(i)}) begin
          errors++;
          $display("FAIL b2b blk%0d round%0d: got obs=%b count=%0d, want obs=%b count=%0d", b, i, obs, count, P_RND, i);
        end
      end
      tick();
      vectors++;
      if ({obs, count} !== {P_FIN, 6'd0}) begin
        errors++;
        $display("FAIL b2b final blk%0d: got obs=%b count=%0d, want obs=%b count=0", b, obs, count, P_FIN);
      end
      if (b == 2) start = 1'b0;
      tick();
    end
    vectors++;
    if ({obs, count} !== {P_IDLE, 6'd0}) begin
      errors++;
      $display("FAIL b2b idle: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_IDLE);
    end
  endtask

  task automatic test_abort();
    // abort with start in IDLE: start dropped
    start = 1'b1; first_block = 1'b1; abort = 1'b1;
    tick();
    vectors++;
    if ({obs, count} !== {P_IDLE, 6'd0}) begin
      errors++;
      $display("FAIL abort+start idle: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_IDLE);
    end
    abort = 1'b0;
    tick();
    start = 1'b0;
    // now in LOAD; run to count 30 then abort
    for (int i = 0; i <= 30; i++) tick();
    vectors++;
    if ({obs, count} !== {P_RND, 6'd30}) begin
      errors++;
      $display("FAIL abort pre: got obs=%b count=%0d, want obs=%b count=30", obs, count, P_RND);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if ({obs, count} !== {P_IDLE, 6'd0}) begin
      errors++;
      $display("FAIL abort round30: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_IDLE);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort no-done cyc%0d: got done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
    // fresh block runs all 64 rounds; abort+start in FINAL then goes IDLE
    start = 1'b1; first_block = 1'b0;
    tick();
    start = 1'b0;
    vectors++;
    if ({obs, count} !== {P_LD, 6'd0}) begin
      errors++;
      $display("FAIL abort restart load: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_LD);
    end
    for (int i = 0; i < 64; i++) begin
      tick();
      vectors++;
      if ({obs, count} !== {P_RND, 6'(i)}) begin
        errors++;
        $display("FAIL abort restart round%0d: got obs=%b count=%0d, want obs=%b count=%0d", i, obs, count, P_RND, i);
      end
    end
    tick();
    vectors++;
    if ({obs, count} !== {P_FIN, 6'd0}) begin
      errors++;
      $display("FAIL abort restart final: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_FIN);
    end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    vectors++;
    if ({obs, count} !== {P_IDLE, 6'd0}) begin
      errors++;
      $display("FAIL abort in final: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_IDLE);
    end
  endtask

  task automatic test_reset_mid_round();
    start = 1'b1; first_block = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 63; i++) tick();
    vectors++;
    if ({obs, count} !== {P_RND, 6'd63}) begin
      errors++;
      $display("FAIL rst-mid pre: got obs=%b count=%0d, want obs=%b count=63", obs, count, P_RND);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({obs, count} !== {P_IDLE, 6'd0}) begin
      errors++;
      $display("FAIL rst-mid at63: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_IDLE);
    end
    tick();
    vectors++;
    if ({obs, count} !== {P_IDLE, 6'd0}) begin
      errors++;
      $display("FAIL rst-mid after: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_IDLE);
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    int rounds;
    dones = 0; rounds = 0;
    start = 1'b1; first_block = 1'b1;
    tick();
    start = 1'b0; first_block = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (round_en && count == 6'd10) start = 1'b1;
      tick();
      start = 1'b0;
      if (done) dones++;
      if (round_en) rounds++;
      if (init_hash) begin
        vectors++;
        errors++;
        $display("FAIL ignore init_hash cyc%0d: got 1, want 0", i);
      end
    end
    vectors++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore done count: got %0d, want 1", dones);
    end
    vectors++;
    if (rounds !== 64) begin
      errors++;
      $display("FAIL ignore round count: got %0d, want 64", rounds);
    end
    vectors++;
    if ({obs, count} !== {P_IDLE, 6'd0}) begin
      errors++;
      $display("FAIL ignore idle: got obs=%b count=%0d, want obs=%b count=0", obs, count, P_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_abort();
    test_reset_mid_round();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
